// File: rtl/sd_spi_cmd_ctrl_if.sv
// Command handshake and SD SPI pin bundle for sd_spi_cmd_ctrl.
interface sd_spi_cmd_ctrl_if;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        busy;
  logic        done;
  logic [7:0]  resp;
  logic        timeout;
  logic        sd_sclk;
  logic        sd_mosi;
  logic        sd_miso;
  logic        sd_cs_n;

  // master: init/read FSM side plus the card driving miso
  modport master (
    output start, cmd_index, cmd_arg, cmd_crc, sd_miso,
    input  busy, done, resp, timeout, sd_sclk, sd_mosi, sd_cs_n
  );
  modport slave (
    input  start, cmd_index, cmd_arg, cmd_crc, sd_miso,
    output busy, done, resp, timeout, sd_sclk, sd_mosi, sd_cs_n
  );
endinterface

// File: rtl/sd_spi_cmd_ctrl.sv
// SD SPI command sequencer: divided sclk, 48-bit command frame out,
// bounded R1 poll, then 8 release clocks before dropping chip select.
module sd_spi_cmd_ctrl #(
  parameter int HALF_DIV = 125,
  parameter int NCR_MAX  = 8
) (
  input  logic              clk,
  input  logic              reset,
  sd_spi_cmd_ctrl_if.slave  bus
);
  localparam int DW     = $clog2(HALF_DIV);
  localparam int WAIT_N = NCR_MAX * 8;
  localparam int CW     = $clog2(((WAIT_N > 48) ? WAIT_N : 48) + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RESP, TAIL} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [47:0]   shreg;
  logic [47:0]   frame;
  logic [1:0]    miso_sync;
  logic [7:0]    resp_q;
  logic          sclk, mosi, cs_n, done_q, to_q;
  logic          busy, accept, tick, rise, fall, miso_s;

  assign frame  = {2'b01, bus.cmd_index, bus.cmd_arg, bus.cmd_crc, 1'b1};
  assign busy   = (state != IDLE) | done_q;
  assign accept = bus.start & ~busy;
  assign tick   = (state != IDLE) && (div == DW'(HALF_DIV - 1));
  assign rise   = tick & ~sclk;
  assign fall   = tick & sclk;
  assign miso_s = miso_sync[1];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = SEND;
      SEND: if (fall && cnt == CW'(48)) state_nx = WAIT;
      WAIT: if (rise) begin
              if (!miso_s)                      state_nx = RESP;
              else if (cnt == CW'(WAIT_N - 1))  state_nx = TAIL;
            end
      RESP: if (rise && cnt == CW'(6)) state_nx = TAIL;
      TAIL: if (fall && cnt == CW'(8)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div       <= '0;
      cnt       <= '0;
      shreg     <= '1;
      miso_sync <= 2'b11;
      resp_q    <= 8'hFF;
      sclk      <= 1'b0;
      mosi      <= 1'b1;
      cs_n      <= 1'b1;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      miso_sync <= {miso_sync[0], bus.sd_miso};
      div       <= (state == IDLE || tick) ? '0 : div + DW'(1);
      sclk      <= (state == IDLE) ? 1'b0 : (tick ? ~sclk : sclk);
      case (state)
        IDLE: if (accept) begin
          shreg  <= {frame[46:0], 1'b1};
          mosi   <= frame[47];
          cs_n   <= 1'b0;
          resp_q <= 8'hFF;
          to_q   <= 1'b0;
          cnt    <= '0;
        end
        SEND: begin
          if (rise) cnt <= cnt + CW'(1);
          if (fall) begin
            if (cnt == CW'(48)) begin
              mosi <= 1'b1;
              cnt  <= '0;
            end else begin
              mosi  <= shreg[47];
              shreg <= {shreg[46:0], 1'b1};
            end
          end
        end
        WAIT: begin
          mosi <= 1'b1;
          if (rise) begin
            if (!miso_s) begin
              // start bit lands in resp[7] after the 7 shifts in RESP
              resp_q <= 8'hFE;
              cnt    <= '0;
            end else if (cnt == CW'(WAIT_N - 1)) begin
              to_q   <= 1'b1;
              resp_q <= 8'hFF;
              cnt    <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        RESP: if (rise) begin
          resp_q <= {resp_q[6:0], miso_s};
          cnt    <= (cnt == CW'(6)) ? '0 : cnt + CW'(1);
        end
        TAIL: begin
          if (rise) cnt <= cnt + CW'(1);
          if (fall && cnt == CW'(8)) begin
            cs_n   <= 1'b1;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy    = busy;
    bus.done    = done_q;
    bus.resp    = resp_q;
    bus.timeout = to_q;
    bus.sd_sclk = sclk;
    bus.sd_mosi = mosi;
    bus.sd_cs_n = cs_n;
  end
endmodule

// File: tb/tb_sd_spi_cmd_ctrl.sv
// Directed bench for sd_spi_cmd_ctrl: fast-divider instance with a card model,
// plus a default-divider instance for clock-width checks.
module tb_sd_spi_cmd_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sd_spi_cmd_ctrl_if bus_a ();
  sd_spi_cmd_ctrl_if bus_d ();

  sd_spi_cmd_ctrl #(.HALF_DIV(2), .NCR_MAX(8)) dut (.clk(clk), .reset(reset), .bus(bus_a));
  sd_spi_cmd_ctrl dut_d (.clk(clk), .reset(reset), .bus(bus_d));

  int errs = 0, checks = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  int dcnt = 0;
  always @(negedge clk) if (bus_a.done) dcnt++;

  // card model: bit for sample s is the R1 byte once s reaches resp_at, else 1
  int          rcnt = 0;
  int          resp_at = 0;
  logic [7:0]  card_byte = 8'h00;
  logic [47:0] mosi_cap = '0;
  logic        mosi_bad = 1'b0;
  logic        miso_a = 1'b1;
  assign bus_a.sd_miso = miso_a;
  assign bus_d.sd_miso = 1'b1;

  function automatic logic card_bit(int s);
    if (resp_at != 0 && s >= resp_at && s < resp_at + 8) return card_byte[7 - (s - resp_at)];
    return 1'b1;
  endfunction

  always @(negedge bus_a.sd_cs_n or posedge bus_a.sd_sclk) begin
    if (bus_a.sd_sclk) begin
      if (!bus_a.sd_cs_n) begin
        rcnt++;
        if (rcnt <= 48) mosi_cap = {mosi_cap[46:0], bus_a.sd_mosi};
        else if (!bus_a.sd_mosi) mosi_bad = 1'b1;
        miso_a = card_bit(rcnt + 1);
      end
    end else begin
      rcnt = 0;
      mosi_cap = '0;
      mosi_bad = 1'b0;
      miso_a = card_bit(1);
    end
  end

  // sclk level run lengths on the default-divider instance
  int   run = 0, hi_min = 1000000, hi_max = 0, lo_min = 1000000, lo_max = 0;
  logic sclk_prev = 1'b0, seen_rise = 1'b0;
  always @(negedge clk) begin
    if (bus_d.sd_sclk !== sclk_prev) begin
      if (sclk_prev) begin
        if (run < hi_min) hi_min = run;
        if (run > hi_max) hi_max = run;
      end else begin
        if (seen_rise) begin
          if (run < lo_min) lo_min = run;
          if (run > lo_max) lo_max = run;
        end
        seen_rise = 1'b1;
      end
      run = 1;
    end else run++;
    sclk_prev = bus_d.sd_sclk;
  end

  int acc_cyc = 0;
  task automatic send_start(logic [5:0] i, logic [31:0] a, logic [6:0] c);
    @(negedge clk);
    bus_a.cmd_index = i; bus_a.cmd_arg = a; bus_a.cmd_crc = c; bus_a.start = 1'b1;
    acc_cyc = cyc + 1;
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  task automatic wait_done(string tag, int limit, output int lat);
    int n = 0;
    while (!bus_a.done && n < limit) begin @(negedge clk); n++; end
    chk({tag, "_done"}, bus_a.done, 1'b1);
    lat = cyc - acc_cyc;
  endtask

  initial begin
    int lat, d0, n;
    logic bad;
    bus_a.start = 1'b0; bus_a.cmd_index = '0; bus_a.cmd_arg = '0; bus_a.cmd_crc = '0;
    bus_d.start = 1'b0; bus_d.cmd_index = '0; bus_d.cmd_arg = '0; bus_d.cmd_crc = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus_a.busy, 1'b0);
    chk("rst_done", bus_a.done, 1'b0);
    chk("rst_resp", bus_a.resp, 8'hFF);
    chk("rst_to", bus_a.timeout, 1'b0);
    chk("rst_sclk", bus_a.sd_sclk, 1'b0);
    chk("rst_mosi", bus_a.sd_mosi, 1'b1);
    chk("rst_cs", bus_a.sd_cs_n, 1'b1);
    reset = 1'b0;

    // CMD0, R1 after two idle bytes
    resp_at = 65; card_byte = 8'h01; d0 = dcnt;
    send_start(6'd0, 32'h0, 7'h4A);
    chk("c0_busy", bus_a.busy, 1'b1);
    chk("c0_cs", bus_a.sd_cs_n, 1'b0);
    wait_done("c0", 2000, lat);
    chk("c0_mosi", mosi_cap, 48'h400000000095);
    chk("c0_resp", bus_a.resp, 8'h01);
    chk("c0_to", bus_a.timeout, 1'b0);
    chk("c0_cs_done", bus_a.sd_cs_n, 1'b1);
    chk("c0_sclk_done", bus_a.sd_sclk, 1'b0);
    chk("c0_rises", rcnt, 80);
    chk("c0_lat", (lat >= 319 && lat <= 321), 1'b1);
    chk("c0_mosi_hi", mosi_bad, 1'b0);
    @(negedge clk);
    chk("c0_pulse", bus_a.done, 1'b0);
    chk("c0_busy_after", bus_a.busy, 1'b0);
    chk("c0_ndone", dcnt - d0, 1);

    // CMD8, R1 on the first wait bit
    resp_at = 49; card_byte = 8'h05;
    send_start(6'd8, 32'h000001AA, 7'h43);
    wait_done("c8", 2000, lat);
    chk("c8_mosi", mosi_cap, 48'h48000001AA87);
    chk("c8_resp", bus_a.resp, 8'h05);
    chk("c8_lat", (lat >= 255 && lat <= 257), 1'b1);
    chk("c8_rises", rcnt, 64);

    // no response at all
    resp_at = 0;
    send_start(6'd0, 32'h0, 7'h4A);
    wait_done("to", 3000, lat);
    chk("to_flag", bus_a.timeout, 1'b1);
    chk("to_resp", bus_a.resp, 8'hFF);
    chk("to_rises", rcnt, 120);
    chk("to_lat", (lat >= 479 && lat <= 481), 1'b1);
    chk("to_mosi_hi", mosi_bad, 1'b0);

    // starts while busy and on the done cycle are dropped
    resp_at = 49; card_byte = 8'h00; d0 = dcnt;
    send_start(6'd17, 32'h00001000, 7'h2A);
    chk("bz_to_clr", bus_a.timeout, 1'b0);
    chk("bz_resp_clr", bus_a.resp, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus_a.cmd_index = 6'd55; bus_a.cmd_arg = 32'h0; bus_a.cmd_crc = 7'h32; bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      repeat (10) @(negedge clk);
    end
    n = 0;
    while (!bus_a.done && n < 2000) begin @(negedge clk); n++; end
    chk("bz_a_done", bus_a.done, 1'b1);
    chk("bz_a_mosi", mosi_cap, 48'h510000100055);
    chk("bz_a_resp", bus_a.resp, 8'h00);
    bus_a.start = 1'b1;
    @(negedge clk);
    chk("bz_done_ign", bus_a.busy, 1'b0);
    acc_cyc = cyc + 1;
    @(negedge clk);
    bus_a.start = 1'b0;
    chk("bz_next_acc", bus_a.busy, 1'b1);
    wait_done("bz_b", 2000, lat);
    chk("bz_b_mosi", mosi_cap, 48'h770000000065);
    chk("bz_ndone", dcnt - d0, 2);

    // reset in the middle of the frame
    resp_at = 65; card_byte = 8'h01;
    send_start(6'd0, 32'h0, 7'h4A);
    n = 0;
    while (rcnt < 20 && n < 500) begin @(negedge clk); n++; end
    chk("mr_reach", rcnt, 20);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_cs", bus_a.sd_cs_n, 1'b1);
    chk("mr_sclk", bus_a.sd_sclk, 1'b0);
    chk("mr_mosi", bus_a.sd_mosi, 1'b1);
    chk("mr_busy", bus_a.busy, 1'b0);
    reset = 1'b0;
    d0 = dcnt;
    repeat (200) @(negedge clk);
    chk("mr_nodone", dcnt - d0, 0);
    resp_at = 49; card_byte = 8'h05;
    send_start(6'd8, 32'h000001AA, 7'h43);
    wait_done("mr_new", 2000, lat);
    chk("mr_new_resp", bus_a.resp, 8'h05);
    chk("mr_new_mosi", mosi_cap, 48'h48000001AA87);

    // default divider smoke run
    @(negedge clk);
    bus_d.cmd_index = 6'd0; bus_d.cmd_arg = 32'h0; bus_d.cmd_crc = 7'h4A; bus_d.start = 1'b1;
    @(negedge clk);
    bus_d.start = 1'b0;
    n = 0;
    while (!bus_d.done && n < 40000) begin @(negedge clk); n++; end
    chk("sm_done", bus_d.done, 1'b1);
    chk("sm_to", bus_d.timeout, 1'b1);
    chk("sm_hi_min", hi_min, 125);
    chk("sm_hi_max", hi_max, 125);
    chk("sm_lo_min", lo_min, 125);
    chk("sm_lo_max", lo_max, 125);
    bad = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (bus_d.sd_sclk || !bus_d.sd_cs_n) bad = 1'b1;
    end
    chk("sm_idle_low", bad, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
